armleo_axi_read_mux_ot: RTL and testbench

- N-host to 1-device AXI4 read interconnect with multiple outstanding transactions.
- AR channel is round-robin arbitrated per transaction and is not held across the R burst.
- Host index is prepended to the downstream ARID; R beats are routed back by RID.
- A per-host outstanding counter throttles AR issue; sits between CPU/DMA read masters and the memory-side AXI port.

---
 rtl/armleo_axi_read_mux_ot.sv | 215 +++++++++++++++++++++
 tb/tb_armleo_axi_read_mux_ot.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleo_axi_read_mux_ot.sv
// armleo_axi_read_mux_ot
//   N-host to 1-device AXI4 read interconnect that allows several bursts in flight.
//   The AR channel is round-robin arbitrated per transaction. It is released after each
//   address handshake and is not held for the data burst. The winning host index is
//   prepended to the downstream ARID. R beats are steered back to their host by the upper
//   RID bits. A per-host outstanding counter stops a host from issuing more than
//   MAX_OUTSTANDING bursts.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   upstream_axi_ar*      : per-host AR channels, host i at slice i of each packed bus
//   upstream_axi_r*       : per-host R channels, host i at slice i of each packed bus
//   downstream_axi_ar*    : device-side AR channel, arid is DS_ID_WIDTH wide
//   downstream_axi_r*     : device-side R channel, rid is DS_ID_WIDTH wide
//   bad_rid               : pulses for each R beat whose host index is out of range
module armleo_axi_read_mux_ot #(
  parameter int HOST_NUMBER     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int HIDX_W         = (HOST_NUMBER > 1) ? $clog2(HOST_NUMBER) : 1,
  localparam int DS_ID_WIDTH    = ID_WIDTH + HIDX_W
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [HOST_NUMBER-1:0]           upstream_axi_arvalid,
  output logic [HOST_NUMBER-1:0]           upstream_axi_arready,
  input  logic [HOST_NUMBER*ADDR_WIDTH-1:0] upstream_axi_araddr,
  input  logic [HOST_NUMBER*8-1:0]         upstream_axi_arlen,
  input  logic [HOST_NUMBER*3-1:0]         upstream_axi_arsize,
  input  logic [HOST_NUMBER*2-1:0]         upstream_axi_arburst,
  input  logic [HOST_NUMBER*ID_WIDTH-1:0]  upstream_axi_arid,
  input  logic [HOST_NUMBER-1:0]           upstream_axi_arlock,
  input  logic [HOST_NUMBER*3-1:0]         upstream_axi_arprot,

  output logic [HOST_NUMBER-1:0]           upstream_axi_rvalid,
  input  logic [HOST_NUMBER-1:0]           upstream_axi_rready,
  output logic [HOST_NUMBER*2-1:0]         upstream_axi_rresp,
  output logic [HOST_NUMBER-1:0]           upstream_axi_rlast,
  output logic [HOST_NUMBER*DATA_WIDTH-1:0] upstream_axi_rdata,
  output logic [HOST_NUMBER*ID_WIDTH-1:0]  upstream_axi_rid,

  output logic                             downstream_axi_arvalid,
  input  logic                             downstream_axi_arready,
  output logic [ADDR_WIDTH-1:0]            downstream_axi_araddr,
  output logic [7:0]                       downstream_axi_arlen,
  output logic [2:0]                       downstream_axi_arsize,
  output logic [1:0]                       downstream_axi_arburst,
  output logic [DS_ID_WIDTH-1:0]           downstream_axi_arid,
  output logic                             downstream_axi_arlock,
  output logic [2:0]                       downstream_axi_arprot,

  input  logic                             downstream_axi_rvalid,
  output logic                             downstream_axi_rready,
  input  logic [1:0]                       downstream_axi_rresp,
  input  logic                             downstream_axi_rlast,
  input  logic [DATA_WIDTH-1:0]            downstream_axi_rdata,
  input  logic [DS_ID_WIDTH-1:0]           downstream_axi_rid,

  output logic                             bad_rid
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [HIDX_W:0]   HOST_LIM = (HIDX_W+1)'(HOST_NUMBER);
  localparam logic [HIDX_W-1:0] HOST_LAST = HIDX_W'(HOST_NUMBER - 1);

  typedef enum logic {ARB = 1'b0, ISSUE = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HIDX_W-1:0] r_sel;
  logic [HIDX_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_cnt [HOST_NUMBER];

  logic [HOST_NUMBER-1:0] w_elig;
  logic [HOST_NUMBER-1:0] w_inc;
  logic [HOST_NUMBER-1:0] w_dec;
  logic [HIDX_W-1:0]      w_pick;
  logic                   w_pick_found;
  logic                   w_ar_hs;
  logic [HIDX_W-1:0]      w_ptr_nxt;
  logic [HIDX_W-1:0]      w_rhost;
  logic                   w_rhost_ok;
  logic                   w_sel_rready;

  // A host may compete only while it has room for another burst in flight.
  always_comb begin
    for (int i = 0; i < HOST_NUMBER; i++) begin
      w_elig[i] = upstream_axi_arvalid[i] && (r_cnt[i] < CNT_MAX);
    end
  end

  // Round-robin pick. The scan runs from the far end toward the pointer, so the eligible
  // host closest to the pointer overwrites any earlier candidate and wins.
  always_comb begin
    int idx;
    idx          = 0;
    w_pick       = r_ptr;
    w_pick_found = 1'b0;
    for (int k = HOST_NUMBER - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= HOST_NUMBER) idx = idx - HOST_NUMBER;
      if (w_elig[idx]) begin
        w_pick       = HIDX_W'(idx);
        w_pick_found = 1'b1;
      end
    end
  end

  assign w_ar_hs   = (r_state == ISSUE) && downstream_axi_arready;
  assign w_ptr_nxt = (r_sel == HOST_LAST) ? '0 : r_sel + 1'b1;

  // AR FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB;
    else     r_state <= w_state_nxt;
  end

  // AR FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB:     if (w_pick_found) w_state_nxt = ISSUE;
      ISSUE:   if (downstream_axi_arready) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // The grant is latched once, in ARB. It is then held until the address handshake,
  // so the downstream arvalid is never withdrawn.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= '0;
      r_ptr <= '0;
    end else begin
      if (r_state == ARB && w_pick_found) r_sel <= w_pick;
      if (w_ar_hs) r_ptr <= w_ptr_nxt;
    end
  end

  // AR FSM: outputs. AR fields are muxed from the selected host.
  always_comb begin
    upstream_axi_arready   = '0;
    downstream_axi_arvalid = (r_state == ISSUE) && !rst;
    downstream_axi_araddr  = '0;
    downstream_axi_arlen   = '0;
    downstream_axi_arsize  = '0;
    downstream_axi_arburst = '0;
    downstream_axi_arid    = '0;
    downstream_axi_arlock  = 1'b0;
    downstream_axi_arprot  = '0;
    for (int i = 0; i < HOST_NUMBER; i++) begin
      if (r_sel == HIDX_W'(i)) begin
        upstream_axi_arready[i] = downstream_axi_arvalid && downstream_axi_arready;
        downstream_axi_araddr   = upstream_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        downstream_axi_arlen    = upstream_axi_arlen[i*8 +: 8];
        downstream_axi_arsize   = upstream_axi_arsize[i*3 +: 3];
        downstream_axi_arburst  = upstream_axi_arburst[i*2 +: 2];
        downstream_axi_arid     = {r_sel, upstream_axi_arid[i*ID_WIDTH +: ID_WIDTH]};
        downstream_axi_arlock   = upstream_axi_arlock[i];
        downstream_axi_arprot   = upstream_axi_arprot[i*3 +: 3];
      end
    end
  end

  // R routing is purely combinational. Only rvalid is steered; the payload is broadcast to
  // every host.
  assign w_rhost    = downstream_axi_rid[DS_ID_WIDTH-1:ID_WIDTH];
  assign w_rhost_ok = ({1'b0, w_rhost} < HOST_LIM);

  always_comb begin
    upstream_axi_rvalid = '0;
    w_sel_rready        = 1'b0;
    for (int i = 0; i < HOST_NUMBER; i++) begin
      if (w_rhost == HIDX_W'(i)) begin
        upstream_axi_rvalid[i] = downstream_axi_rvalid && !rst;
        w_sel_rready           = upstream_axi_rready[i];
      end
    end
  end

  // A beat that belongs to no host is accepted and dropped, so the device cannot stall.
  assign downstream_axi_rready = !rst && (w_rhost_ok ? w_sel_rready : 1'b1);
  assign bad_rid               = !rst && downstream_axi_rvalid && !w_rhost_ok;

  assign upstream_axi_rdata = {HOST_NUMBER{downstream_axi_rdata}};
  assign upstream_axi_rresp = {HOST_NUMBER{downstream_axi_rresp}};
  assign upstream_axi_rlast = {HOST_NUMBER{downstream_axi_rlast}};
  assign upstream_axi_rid   = {HOST_NUMBER{downstream_axi_rid[ID_WIDTH-1:0]}};

  // Outstanding counters. An issue and a completion for the same host in the same cycle
  // cancel out. A completion that arrives while the counter is 0 is ignored.
  always_comb begin
    for (int i = 0; i < HOST_NUMBER; i++) begin
      w_inc[i] = w_ar_hs && (r_sel == HIDX_W'(i));
      w_dec[i] = downstream_axi_rvalid && downstream_axi_rready && downstream_axi_rlast
                 && w_rhost_ok && (w_rhost == HIDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HOST_NUMBER; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < HOST_NUMBER; i++) begin
        if (w_inc[i] && !w_dec[i])                      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_armleo_axi_read_mux_ot.sv
module tb_armleo_axi_read_mux_ot;

  localparam int H    = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int IDW  = 4;
  localparam int MAXO = 2;
  localparam int HW   = 2;
  localparam int DSW  = IDW + HW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [H-1:0]     up_arvalid, up_arready, up_arlock;
  logic [H*AW-1:0]  up_araddr;
  logic [H*8-1:0]   up_arlen;
  logic [H*3-1:0]   up_arsize, up_arprot;
  logic [H*2-1:0]   up_arburst;
  logic [H*IDW-1:0] up_arid;
  logic [H-1:0]     up_rvalid, up_rready, up_rlast;
  logic [H*2-1:0]   up_rresp;
  logic [H*DW-1:0]  up_rdata;
  logic [H*IDW-1:0] up_rid;

  logic           ds_arvalid, ds_arready, ds_arlock;
  logic [AW-1:0]  ds_araddr;
  logic [7:0]     ds_arlen;
  logic [2:0]     ds_arsize, ds_arprot;
  logic [1:0]     ds_arburst;
  logic [DSW-1:0] ds_arid;
  logic           ds_rvalid, ds_rready, ds_rlast;
  logic [1:0]     ds_rresp;
  logic [DW-1:0]  ds_rdata;
  logic [DSW-1:0] ds_rid;
  logic           bad_rid;

  armleo_axi_read_mux_ot #(
    .HOST_NUMBER(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .upstream_axi_arvalid(up_arvalid), .upstream_axi_arready(up_arready),
    .upstream_axi_araddr(up_araddr), .upstream_axi_arlen(up_arlen),
    .upstream_axi_arsize(up_arsize), .upstream_axi_arburst(up_arburst),
    .upstream_axi_arid(up_arid), .upstream_axi_arlock(up_arlock),
    .upstream_axi_arprot(up_arprot),
    .upstream_axi_rvalid(up_rvalid), .upstream_axi_rready(up_rready),
    .upstream_axi_rresp(up_rresp), .upstream_axi_rlast(up_rlast),
    .upstream_axi_rdata(up_rdata), .upstream_axi_rid(up_rid),
    .downstream_axi_arvalid(ds_arvalid), .downstream_axi_arready(ds_arready),
    .downstream_axi_araddr(ds_araddr), .downstream_axi_arlen(ds_arlen),
    .downstream_axi_arsize(ds_arsize), .downstream_axi_arburst(ds_arburst),
    .downstream_axi_arid(ds_arid), .downstream_axi_arlock(ds_arlock),
    .downstream_axi_arprot(ds_arprot),
    .downstream_axi_rvalid(ds_rvalid), .downstream_axi_rready(ds_rready),
    .downstream_axi_rresp(ds_rresp), .downstream_axi_rlast(ds_rlast),
    .downstream_axi_rdata(ds_rdata), .downstream_axi_rid(ds_rid),
    .bad_rid(bad_rid)
  );

  typedef struct {
    int         host;
    logic [52:0] fields;   // {addr, len, size, burst, id, lock, prot}
  } ar_t;

  typedef struct {
    int          host;     // H means "no host": the beat must be dropped with bad_rid
    logic [38:0] payload;  // {id, data, resp, last}
  } rb_t;

  ar_t        exp_ar[$];
  rb_t        exp_r[$];
  logic [DSW-1:0] pend_id[$];
  int         pend_left[$];

  int checks = 0;
  int errors = 0;

  // Shared between the stimulus and the monitor.
  logic [H-1:0] ar_hs_flag;
  logic         r_hs_flag;
  int           req_pct;
  int           cur_k;

  // Reference model state
  int           cnt_m [H];
  int           ptr_m;
  logic [H-1:0] prev_elig;
  logic         prev_arv, prev_ar_hs, prev_rst;
  logic [DSW-1:0] prev_arid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int rr_pick(input logic [H-1:0] elig, input int ptr);
    for (int k = 0; k < H; k++) begin
      if (elig[(ptr + k) % H]) return (ptr + k) % H;
    end
    return -1;
  endfunction

  // Monitor / scoreboard, sampling on the inactive edge
  always @(negedge clk) begin
    logic [H-1:0] elig_now;
    int inc [H];
    int dec [H];
    for (int i = 0; i < H; i++) begin
      inc[i] = 0;
      dec[i] = 0;
    end
    if (rst) begin
      chk("reset_outputs",
          {up_arready, up_rvalid, ds_arvalid, ds_rready, bad_rid},
          {{(2*H){1'b0}}, 3'b000});
      for (int i = 0; i < H; i++) cnt_m[i] = 0;
      ptr_m      = 0;
      prev_rst   = 1'b1;
      prev_arv   = 1'b0;
      prev_ar_hs = 1'b0;
      prev_elig  = '0;
      ar_hs_flag = '0;
      r_hs_flag  = 1'b0;
    end else begin
      for (int i = 0; i < H; i++) elig_now[i] = up_arvalid[i] && (cnt_m[i] < MAXO);

      // AR arbitration behaviour
      if (prev_rst) begin
        chk("arvalid_after_reset", ds_arvalid, 1'b0);
      end else if (prev_ar_hs) begin
        chk("arb_gap", ds_arvalid, 1'b0);
      end else if (prev_arv) begin
        chk("ar_hold", {ds_arvalid, ds_arid}, {1'b1, prev_arid});
      end else if (prev_elig != '0) begin
        chk("rr_grant", {ds_arvalid, 6'(ds_arid[DSW-1:IDW])},
            {1'b1, 6'(rr_pick(prev_elig, ptr_m))});
      end else begin
        chk("arb_idle", ds_arvalid, 1'b0);
      end

      if (ds_arvalid) begin
        logic [H-1:0] oh;
        oh = '0;
        if (int'(ds_arid[DSW-1:IDW]) < H) oh[ds_arid[DSW-1:IDW]] = ds_arready;
        chk("arready_route", up_arready, oh);
      end else begin
        chk("arready_idle", up_arready, '0);
      end

      if (ds_arvalid && ds_arready) begin
        int h;
        int fidx;
        h    = int'(ds_arid[DSW-1:IDW]);
        fidx = -1;
        foreach (exp_ar[q]) if (exp_ar[q].host == h && fidx < 0) fidx = q;
        checks++;
        if (fidx < 0) begin
          errors++;
          $display("FAIL ar_unexpected actual_arid=%0h required=a pending request", ds_arid);
        end else begin
          chk("ar_fields",
              {ds_araddr, ds_arlen, ds_arsize, ds_arburst, ds_arid[IDW-1:0], ds_arlock, ds_arprot},
              exp_ar[fidx].fields);
          exp_ar.delete(fidx);
          pend_id.push_back(ds_arid);
          pend_left.push_back(int'(ds_arlen) + 1);
          inc[h] = 1;
          ptr_m  = (h + 1) % H;
        end
      end
      ar_hs_flag = up_arvalid & up_arready;

      // R routing
      if (ds_rvalid) begin
        int h;
        h = int'(ds_rid[DSW-1:IDW]);
        if (h < H) begin
          logic [H-1:0] oh;
          oh    = '0;
          oh[h] = 1'b1;
          chk("r_route", {up_rvalid, bad_rid, ds_rready}, {oh, 1'b0, up_rready[h]});
          if (ds_rready && ds_rlast) dec[h] = 1;
        end else begin
          chk("bad_rid_beat", {up_rvalid, bad_rid, ds_rready}, {{H{1'b0}}, 2'b11});
        end
      end else begin
        chk("r_idle", {up_rvalid, bad_rid}, '0);
      end

      for (int j = 0; j < H; j++) begin
        if (up_rvalid[j] && up_rready[j]) begin
          checks++;
          if (exp_r.size() == 0) begin
            errors++;
            $display("FAIL r_unexpected actual_host=%0d required=no beat", j);
          end else begin
            rb_t e;
            e = exp_r.pop_front();
            chk("r_beat",
                {8'(j), up_rid[j*IDW +: IDW], up_rdata[j*DW +: DW], up_rresp[j*2 +: 2], up_rlast[j]},
                {8'(e.host), e.payload});
          end
        end
      end
      if (bad_rid) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL bad_unexpected actual=bad_rid required=no beat");
        end else begin
          rb_t e;
          e = exp_r.pop_front();
          chk("bad_beat_host", 8'(e.host), 8'(H));
        end
      end
      r_hs_flag = ds_rvalid && ds_rready;

      for (int i = 0; i < H; i++) begin
        if (inc[i] == 1 && dec[i] == 0) cnt_m[i] = cnt_m[i] + 1;
        else if (dec[i] == 1 && inc[i] == 0 && cnt_m[i] > 0) cnt_m[i] = cnt_m[i] - 1;
      end

      prev_elig  = elig_now;
      prev_arv   = ds_arvalid;
      prev_ar_hs = ds_arvalid && ds_arready;
      prev_arid  = ds_arid;
      prev_rst   = 1'b0;
    end
  end

  task automatic host_step();
    for (int i = 0; i < H; i++) begin
      if (up_arvalid[i] && ar_hs_flag[i]) up_arvalid[i] = 1'b0;
      if (!up_arvalid[i] && $urandom_range(99) < req_pct) begin
        ar_t e;
        logic [AW-1:0] a;
        logic [7:0]    l;
        logic [2:0]    sz, pr;
        logic [1:0]    bu;
        logic [IDW-1:0] id;
        logic          lk;
        a  = $urandom;
        l  = 8'($urandom_range(3));
        sz = 3'($urandom_range(7));
        pr = 3'($urandom_range(7));
        bu = 2'($urandom_range(3));
        id = IDW'($urandom_range(15));
        lk = 1'($urandom_range(1));
        up_araddr[i*AW +: AW]   = a;
        up_arlen[i*8 +: 8]      = l;
        up_arsize[i*3 +: 3]     = sz;
        up_arburst[i*2 +: 2]    = bu;
        up_arid[i*IDW +: IDW]   = id;
        up_arlock[i]            = lk;
        up_arprot[i*3 +: 3]     = pr;
        up_arvalid[i]           = 1'b1;
        e.host   = i;
        e.fields = {a, l, sz, bu, id, lk, pr};
        exp_ar.push_back(e);
      end
      up_rready[i] = ($urandom_range(99) < 70);
    end
    ds_arready = ($urandom_range(99) < 70);
  endtask

  task automatic dev_step();
    if (ds_rvalid && r_hs_flag) begin
      if (cur_k >= 0) begin
        pend_left[cur_k] = pend_left[cur_k] - 1;
        if (pend_left[cur_k] == 0) begin
          pend_left.delete(cur_k);
          pend_id.delete(cur_k);
        end
      end
      ds_rvalid = 1'b0;
    end
    if (!ds_rvalid && $urandom_range(99) < 60) begin
      rb_t e;
      if ($urandom_range(99) < 6) begin
        cur_k     = -1;
        ds_rid    = {HW'(3), IDW'($urandom_range(15))};
        ds_rlast  = 1'($urandom_range(1));
        ds_rvalid = 1'b1;
      end else if (pend_id.size() > 0) begin
        cur_k     = $urandom_range(pend_id.size() - 1);
        ds_rid    = pend_id[cur_k];
        ds_rlast  = (pend_left[cur_k] == 1);
        ds_rvalid = 1'b1;
      end
      if (ds_rvalid) begin
        ds_rdata  = $urandom;
        ds_rresp  = 2'($urandom_range(3));
        e.host    = (int'(ds_rid[DSW-1:IDW]) < H) ? int'(ds_rid[DSW-1:IDW]) : H;
        e.payload = {ds_rid[IDW-1:0], ds_rdata, ds_rresp, ds_rlast};
        exp_r.push_back(e);
      end
    end
  endtask

  task automatic clear_stim();
    up_arvalid = '0;
    up_araddr  = '0;
    up_arlen   = '0;
    up_arsize  = '0;
    up_arburst = '0;
    up_arid    = '0;
    up_arlock  = '0;
    up_arprot  = '0;
    up_rready  = '0;
    ds_arready = 1'b0;
    ds_rvalid  = 1'b0;
    ds_rlast   = 1'b0;
    ds_rresp   = '0;
    ds_rdata   = '0;
    ds_rid     = '0;
    cur_k      = -1;
    exp_ar.delete();
    exp_r.delete();
    pend_id.delete();
    pend_left.delete();
  endtask

  initial begin
    bit drained;
    rst     = 1'b1;
    req_pct = 0;
    clear_stim();
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // Heavy traffic: all hosts contend, counters saturate, and the device reorders
    // and interleaves responses.
    req_pct = 60;
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk); #1;
      host_step();
      dev_step();
    end

    // Reset in the middle of traffic
    @(posedge clk); #1;
    rst = 1'b1;
    clear_stim();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    req_pct = 35;
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk); #1;
      host_step();
      dev_step();
    end

    // Drain: no new requests; everything in flight must complete.
    req_pct = 0;
    drained = 1'b0;
    for (int c = 0; c < 4000 && !drained; c++) begin
      @(posedge clk); #1;
      host_step();
      dev_step();
      drained = (exp_ar.size() == 0) && (pend_id.size() == 0) && !ds_rvalid && (exp_r.size() == 0);
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL drain_timeout actual ar=%0d bursts=%0d beats=%0d required=0",
               exp_ar.size(), pend_id.size(), exp_r.size());
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
